// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
//   Iterative multiply/divide unit that owns the HI/LO register pair. It sits in EX
//   beside the ALU. The hi/lo outputs feed the writeback-select mux (MFHI/MFLO), and
//   busy tells the hazard unit to stall MFHI/MFLO and any new mul/div.
//
//   Parameters
//     WIDTH   operand width; hi/lo are WIDTH bits; one iteration per operand bit
//
//   Ports
//     Clk     in   rising-edge clock
//     Rst     in   synchronous active-high reset (also aborts an op in flight)
//     start   in   request, sampled only while idle
//     op      in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//     inA     in   rs operand (multiplicand / dividend / MTHI-MTLO data)
//     inB     in   rt operand (multiplier / divisor)
//     flush   in   abort the in-flight op; hi/lo keep their old values
//     hi      out  HI register
//     lo      out  LO register
//     busy    out  operation in flight
//     done    out  one-cycle pulse after hi/lo are committed by a mul/div
//
//   Configuration macro
//     MULDIV_FAST_MULT_EN  when defined, MULT/MULTU use one combinational multiply and
//                          commit at the edge that accepts them. Divides stay iterative.

module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateType;

  stateType         state;
  stateType         nextState;
  logic [CW-1:0]    counter;

  logic             isDiv;
  logic             isSigned;
  logic             negA;
  logic             negB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  logic             startOk;
  logic             reqSigned;
  logic             reqDiv;
  logic             reqMulDiv;
  logic             reqNegA;
  logic             reqNegB;
  logic [WIDTH-1:0] inAMag;
  logic [WIDTH-1:0] inBMag;
  logic             launchIter;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     remShift;
  logic [WIDTH:0]     remDiff;
  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   quoNext;

  logic               divZero;
  logic               negResult;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

`ifdef MULDIV_FAST_MULT_EN
  logic               fastMul;
  logic [2*WIDTH-1:0] extA;
  logic [2*WIDTH-1:0] extB;
  logic [2*WIDTH-1:0] fastProd;
`endif

  // Request decode. Flush beats start, so a squashed instruction is never accepted.
  // Signed ops work on magnitudes; negating the most negative value gives 2^(W-1),
  // which still fits exactly as an unsigned W-bit magnitude.
  always_comb begin
    startOk   = start && !flush && (state == IDLE);
    reqSigned = ~op[0];
    reqDiv    = op[1];
    reqMulDiv = ~op[2];
    reqNegA   = reqSigned & inA[WIDTH-1];
    reqNegB   = reqSigned & inB[WIDTH-1];
    inAMag    = reqNegA ? -inA : inA;
    inBMag    = reqNegB ? -inB : inB;
`ifdef MULDIV_FAST_MULT_EN
    launchIter = startOk && reqMulDiv && reqDiv;
    fastMul    = startOk && reqMulDiv && !reqDiv;
    extA       = {{WIDTH{reqNegA}}, inA};
    extB       = {{WIDTH{reqNegB}}, inB};
    fastProd   = extA * extB;
`else
    launchIter = startOk && reqMulDiv;
`endif
  end

  // One iteration step of each algorithm. The multiply adds the multiplicand into the
  // upper half when the current multiplier bit is set, then shifts right with carry.
  // The restoring divide shifts the next dividend bit into the partial remainder and
  // keeps the subtraction only when it does not go negative.
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, magA};
    mulNext  = acc[0] ? {mulSum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    remShift = {rem, quo[WIDTH-1]};
    remDiff  = remShift - {1'b0, magB};
    remNext  = remDiff[WIDTH] ? remShift[WIDTH-1:0] : remDiff[WIDTH-1:0];
    quoNext  = {quo[WIDTH-2:0], ~remDiff[WIDTH]};
  end

  // Sign fixup for the commit. With a zero divisor the loop already leaves the dividend
  // magnitude in the remainder, so the dividend sign restores inA exactly; the quotient
  // is forced to all ones regardless of sign.
  always_comb begin
    divZero   = (magB == '0);
    negResult = isSigned & (negA ^ negB);
    prodFix   = negResult ? -acc : acc;
    quoFix    = divZero ? '1 : (negResult ? -quo : quo);
    remFix    = (isSigned & negA) ? -rem : rem;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: IDLE -> RUN for WIDTH cycles -> FIX for one cycle -> IDLE.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (launchIter) nextState = RUN;
      RUN: begin
        if (flush) begin
          nextState = IDLE;
        end else if (counter == LAST) begin
          nextState = FIX;
        end
      end
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs derived from the state.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: operand latch, iteration registers, HI/LO and the done pulse.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      counter  <= '0;
      isDiv    <= 1'b0;
      isSigned <= 1'b0;
      negA     <= 1'b0;
      negB     <= 1'b0;
      magA     <= '0;
      magB     <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (startOk && (op == 3'd4)) hi <= inA;
          if (startOk && (op == 3'd5)) lo <= inA;
          if (launchIter) begin
            isDiv    <= reqDiv;
            isSigned <= reqSigned;
            negA     <= reqNegA;
            negB     <= reqNegB;
            magA     <= inAMag;
            magB     <= inBMag;
            acc      <= {{WIDTH{1'b0}}, inBMag};
            rem      <= '0;
            quo      <= inAMag;
            counter  <= '0;
          end
`ifdef MULDIV_FAST_MULT_EN
          if (fastMul) begin
            hi   <= fastProd[2*WIDTH-1:WIDTH];
            lo   <= fastProd[WIDTH-1:0];
            done <= 1'b1;
          end
`endif
        end
        RUN: begin
          if (flush) begin
            counter <= '0;
          end else begin
            if (isDiv) begin
              rem <= remNext;
              quo <= quoNext;
            end else begin
              acc <= mulNext;
            end
            counter <= (counter == LAST) ? '0 : counter + 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            if (isDiv) begin
              hi <= remFix;
              lo <= quoFix;
            end else begin
              hi <= prodFix[2*WIDTH-1:WIDTH];
              lo <= prodFix[WIDTH-1:0];
            end
            done <= 1'b1;
          end
        end
        default: begin
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit
//   Directed, table-driven bench for muldiv_hilo_unit (WIDTH = 32), followed by
//   hand-written sequences for MTHI/MTLO, ignored starts, flush and mid-op reset.

module tb_muldiv_hilo_unit;

  localparam int W = 32;

`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         flush;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .op    (op),
    .inA   (inA),
    .inB   (inB),
    .flush (flush),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vecType;

  vecType vecs[12];

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endfunction

  // Presents a request for one cycle; returns at the negedge just after the edge that
  // sampled it.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    op    = o;
    inA   = a;
    inB   = b;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until done shows up, bounded so a stuck DUT cannot hang the run.
  task automatic waitDone(output int busyCycles, output bit seen);
    busyCycles = 0;
    seen       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busyCycles++;
      @(negedge Clk);
    end
  endtask

  initial begin
    int bc;
    bit seen;
    int expBusy;
    int doneCount;

    vecs[0]  = '{"mult_neg2x3",     3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu_max",       3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"div_m7_2",        3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_100_7",      3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{"divu_5_0",        3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[5]  = '{"div_min_m1",      3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{"mult_6x7",        3'd0, 32'd6,        32'd7,        32'd0,        32'd42};
    vecs[7]  = '{"div_7_m2",        3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{"div_m8_0",        3'd2, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[9]  = '{"mult_min_min",    3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{"mult_max_m1",     3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vecs[11] = '{"divu_max_16",     3'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};

    Rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd7;
    inA   = '0;
    inB   = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    checkOutput("reset_hi",   hi,   32'h0);
    checkOutput("reset_lo",   lo,   32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      expBusy = (FAST && !vecs[i].op[1]) ? 0 : W + 1;
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(bc, seen);
      checkOutput({vecs[i].name, "_done_seen"}, {31'b0, seen}, 32'h1);
      checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].expHi);
      checkOutput({vecs[i].name, "_lo"}, lo, vecs[i].expLo);
      checkOutput({vecs[i].name, "_busy_cycles"}, 32'(bc), 32'(expBusy));
      checkOutput({vecs[i].name, "_busy_at_done"}, {31'b0, busy}, 32'h0);
      @(negedge Clk);
      checkOutput({vecs[i].name, "_done_pulse"}, {31'b0, done}, 32'h0);
    end

    // MTHI/MTLO write immediately without busy or done.
    applyStimulus(3'd4, 32'h00001234, 32'h0);
    checkOutput("mthi_hi",   hi, 32'h00001234);
    checkOutput("mthi_busy", {31'b0, busy}, 32'h0);
    checkOutput("mthi_done", {31'b0, done}, 32'h0);
    applyStimulus(3'd5, 32'h00005678, 32'h0);
    checkOutput("mtlo_lo",   lo, 32'h00005678);
    checkOutput("mtlo_hi",   hi, 32'h00001234);

    // Long op, an ignored start mid-run, then a flush at cycle 10.
    applyStimulus(FAST ? 3'd3 : 3'd0, 32'd3, 32'd5);
    checkOutput("run_busy", {31'b0, busy}, 32'h1);
    repeat (2) @(negedge Clk);
    op    = 3'd4;
    inA   = 32'hDEADBEEF;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (5) @(negedge Clk);
    flush = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
    checkOutput("flush_busy", {31'b0, busy}, 32'h0);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) doneCount++;
      @(negedge Clk);
    end
    checkOutput("flush_no_done", 32'(doneCount), 32'h0);
    checkOutput("flush_hi_kept", hi, 32'h00001234);
    checkOutput("flush_lo_kept", lo, 32'h00005678);

    // Reset in the middle of a divide.
    applyStimulus(3'd2, 32'd1000, 32'd3);
    repeat (4) @(negedge Clk);
    checkOutput("div_pre_reset_busy", {31'b0, busy}, 32'h1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    checkOutput("midrst_hi",   hi, 32'h0);
    checkOutput("midrst_lo",   lo, 32'h0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
    checkOutput("midrst_done", {31'b0, done}, 32'h0);

    // The unit still works after flush and reset.
    applyStimulus(3'd3, 32'd100, 32'd7);
    waitDone(bc, seen);
    checkOutput("recover_done_seen", {31'b0, seen}, 32'h1);
    checkOutput("recover_hi", hi, 32'd2);
    checkOutput("recover_lo", lo, 32'd14);
    checkOutput("recover_busy_cycles", 32'(bc), 32'(W + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
